// File: rtl/q_measure.sv
// rtl/q_measure.sv - settle-then-average Q measurement front end for the current tuning loop
module q_measure #(
   parameter int BUS_WIDTH     = 10,
   parameter int ADC_WIDTH     = 12,
   parameter int LOG2_AVG      = 4,
   parameter int SETTLE_CYCLES = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [BUS_WIDTH-1:0] i_ref,
   input  logic [ADC_WIDTH-1:0] adc_data,
   input  logic                 adc_valid,
   output logic [BUS_WIDTH-1:0] q_measured,
   output logic                 ready,
   output logic                 busy,
   output logic [7:0]           meas_count
);

   localparam int ACC_W = ADC_WIDTH + LOG2_AVG;
   localparam int SHIFT = LOG2_AVG + ADC_WIDTH - BUS_WIDTH;
   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [LOG2_AVG:0] LAST_SAMP   = (LOG2_AVG+1)'((1 << LOG2_AVG) - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, ACQUIRE, DONE} state_t;

   state_t                state, state_next;
   logic [BUS_WIDTH-1:0]  ref_q, ref_next;
   logic [CNT_W-1:0]      settle_cnt, settle_next;
   logic [ACC_W-1:0]      acc, acc_next, acc_sum;
   logic [LOG2_AVG:0]     samp_cnt, samp_next;
   logic                  done_next;

   // acc_sum includes the current sample so the final average is ready on the DONE edge
   assign acc_sum = acc + ACC_W'(adc_data);

   always_comb begin
      state_next  = state;
      ref_next    = ref_q;
      settle_next = settle_cnt;
      acc_next    = acc;
      samp_next   = samp_cnt;
      done_next   = 1'b0;
      case (state)
         IDLE: begin
            if (enable) begin
               state_next  = SETTLE;
               ref_next    = i_ref;
               settle_next = SETTLE_LOAD;
            end
         end
         SETTLE, ACQUIRE: begin
            if (i_ref != ref_q) begin
               state_next  = SETTLE;
               ref_next    = i_ref;
               settle_next = SETTLE_LOAD;
               acc_next    = '0;
               samp_next   = '0;
            end else if (state == SETTLE) begin
               if (settle_cnt == '0) begin
                  state_next = ACQUIRE;
                  acc_next   = '0;
                  samp_next  = '0;
               end else begin
                  settle_next = settle_cnt - CNT_W'(1);
               end
            end else if (adc_valid) begin
               acc_next  = acc_sum;
               samp_next = samp_cnt + (LOG2_AVG+1)'(1);
               if (samp_cnt == LAST_SAMP) begin
                  state_next = DONE;
                  done_next  = 1'b1;
               end
            end
         end
         DONE: begin
            state_next  = SETTLE;
            ref_next    = i_ref;
            settle_next = SETTLE_LOAD;
         end
         default: state_next = IDLE;
      endcase
      // enable low wins over everything, including a completing window
      if (!enable) begin
         state_next = IDLE;
         done_next  = 1'b0;
         ref_next   = ref_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         ref_q      <= '0;
         settle_cnt <= '0;
         acc        <= '0;
         samp_cnt   <= '0;
         q_measured <= '0;
         ready      <= 1'b0;
         busy       <= 1'b0;
         meas_count <= '0;
      end else begin
         state      <= state_next;
         ref_q      <= ref_next;
         settle_cnt <= settle_next;
         acc        <= acc_next;
         samp_cnt   <= samp_next;
         ready      <= done_next;
         busy       <= (state_next == SETTLE) || (state_next == ACQUIRE);
         if (done_next) begin
            q_measured <= acc_sum[ACC_W-1:SHIFT];
            meas_count <= meas_count + 8'd1;
         end
      end
   end

endmodule

// File: doc/q_measure.md
# q_measure

Measurement front end that closes the tuning loop opposite the bisection current controller. It takes the controller's `i_ref` and a stream of Q-estimate samples from the resonator ADC, waits a settling interval after each new `i_ref`, and averages a power-of-two window of samples. It then presents the result as `q_measured` with a one-cycle `ready` strobe. It re-arms automatically, so the controller sees one fresh measurement per `i_ref` step.

## Interface
- `BUS_WIDTH`, 10, width of `i_ref` and `q_measured`
- `ADC_WIDTH`, 12, width of `adc_data`; must be ≥ `BUS_WIDTH`
- `LOG2_AVG`, 4, averaging window is N = 2^`LOG2_AVG` valid samples
- `SETTLE_CYCLES`, 64, clock cycles to wait after `i_ref` is latched; must be ≥ 1
- `clk` in 1: clock clk
- `rst` in 1: reset rst, asynchronous, active-high
- `enable` in 1: measurement run enable
- `i_ref` in `BUS_WIDTH`: current reference from controller
- `adc_data` in `ADC_WIDTH`: unsigned Q-estimate sample
- `adc_valid` in 1: `adc_data` valid this cycle
- `q_measured` out `BUS_WIDTH`: averaged, rescaled measurement; registered
- `ready` out 1: one-cycle pulse, `q_measured` updated this cycle
- `busy` out 1: high in SETTLE and ACQUIRE
- `meas_count` out 8: completed measurements, wraps 255→0

## Operation
- The FSM has four states: IDLE, SETTLE, ACQUIRE and DONE.
- **IDLE**
  - `enable`=1 moves to SETTLE.
  - Latch `i_ref` into `ref_q` and load `settle_cnt` = `SETTLE_CYCLES`-1.
- **SETTLE**
  - `settle_cnt` decrements each cycle.
  - At `settle_cnt`==0, move to ACQUIRE and clear `acc` and `samp_cnt`.
  - `adc_valid` is ignored.
- **ACQUIRE**
  - On `adc_valid`=1: `acc` += `adc_data` and `samp_cnt` += 1.
  - When the N-th valid sample is accepted, move to DONE.
  - Cycles with `adc_valid`=0 add nothing; there is no timeout.
- **DONE** (exactly one cycle)
  - `ready`=1 and `meas_count` += 1.
  - Move to SETTLE, re-latching `i_ref` and reloading `settle_cnt`.
  - `adc_valid` is ignored.
- **`q_measured` update**
  - Registered on the ACQUIRE→DONE edge: `q_measured` = `acc` >> (`LOG2_AVG` + `ADC_WIDTH` − `BUS_WIDTH`).
  - Truncation only, no rounding.
  - Holds its value in every other state.
- **Arithmetic**
  - `acc` width is `ADC_WIDTH`+`LOG2_AVG`, unsigned; it cannot overflow.
  - `samp_cnt` width is `LOG2_AVG`+1.
- **Reference change**
  - If `i_ref` ≠ `ref_q` in SETTLE or ACQUIRE, the state becomes SETTLE next cycle.
  - `ref_q` takes the new `i_ref`, `settle_cnt` reloads and `acc`/`samp_cnt` are discarded.
  - No `ready` is produced for the aborted window.
  - This check has priority over the SETTLE→ACQUIRE and ACQUIRE→DONE transitions in the same cycle.
- **Enable low**
  - `enable`=0 in any state moves to IDLE next cycle, with priority over all other transitions.
  - If the N-th sample arrives in the same cycle, it is discarded and no `ready` is produced.
  - `q_measured` and `meas_count` hold.
- **Reset**
  - Asynchronous; effective mid-operation.
  - State IDLE, `q_measured`=0, `ready`=0, `busy`=0, `meas_count`=0, `acc`=0, `samp_cnt`=0, `settle_cnt`=0, `ref_q`=0.

## Timing
- All outputs are registered and take their reset values while `rst` is high.
- Edge numbering: `enable` is first sampled high at edge 0.
  - SETTLE occupies cycles 1…`SETTLE_CYCLES`.
  - ACQUIRE starts at cycle `SETTLE_CYCLES`+1.
- With continuous `adc_valid`, `ready` is high in cycle `SETTLE_CYCLES`+N+1, and `q_measured` shows the new value in that same cycle.
- Each valid-gap cycle in ACQUIRE delays `ready` by one cycle.
- Measurement period with continuous valid and constant `i_ref`: `SETTLE_CYCLES`+N+1 cycles.
- `busy` is high in SETTLE/ACQUIRE and low in DONE and IDLE.
- `ready` is never high in two consecutive cycles.
- The controller may change `i_ref` at any cycle after `ready`; a change in the DONE cycle itself is picked up by the re-latch at the SETTLE entry.

## Test plan
All scenarios use `BUS_WIDTH`=10, `ADC_WIDTH`=12, `LOG2_AVG`=2, `SETTLE_CYCLES`=4.
- **Constant input:** `enable` high, `adc_data`=0x800 continuous valid → `ready` in cycle 9, `q_measured`=0x200, `meas_count`=1; next `ready` in cycle 18.
- **Averaging and truncation:** samples 100, 200, 300, 400 → sum 1000, `q_measured`=1000>>4=62. Full-scale 0xFFF×4 → `q_measured`=0x3FF with no wrap.
- **Valid gaps:** `adc_valid` toggling 1,0,1,0… → `ready` at cycle 12. Samples offered during SETTLE and DONE are not accumulated (drive 0xFFF there, 0x400 in ACQUIRE → `q_measured`=0x100).
- **Reference change:** `i_ref` 0x100→0x180 after 2 samples of ACQUIRE → returns to SETTLE, no `ready` for the aborted window; `ready` arrives 9 cycles after the change, and the average contains only post-change samples.
- **Enable drop and reset:**
  - `enable` low together with the 4th sample → IDLE, no `ready`, `q_measured` unchanged.
  - `rst` pulsed mid-ACQUIRE → all outputs return to their reset values immediately; restart timing again matches scenario 1.
- **Counter wrap:** run 256 measurements → `meas_count` wraps to 0 and `ready` is never high in consecutive cycles.
